rram_instr_arbiter: RTL

// Merges NUM_SRC instruction/data FIFO pairs (e.g. ext host, HD engine) into one instruction stream and one data stream.

---
 rtl/rram_instr_arbiter_if.sv | 39 +++
 rtl/rram_instr_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rram_instr_arbiter_if.sv
// Bundle of FIFO-side and controller-side signals for the RRAM instruction arbiter.
// master = arbiter (drives pops and controller outputs), slave = FIFOs + controller.
interface rram_instr_arbiter_if #(
   parameter int NUM_SRC      = 2,
   parameter int INSTR_WIDTH  = 4,
   parameter int OPCODE_WIDTH = 16,
   parameter int DATAIN_WIDTH = 64
);
   localparam int EW    = INSTR_WIDTH + OPCODE_WIDTH;
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]              empty_instFIFO;
   logic [NUM_SRC*EW-1:0]           dout_instFIFO;
   logic [NUM_SRC-1:0]              pop_n_instFIFO;
   logic [NUM_SRC-1:0]              empty_iFIFO;
   logic [NUM_SRC*DATAIN_WIDTH-1:0] dout_iFIFO;
   logic [NUM_SRC-1:0]              pop_n_iFIFO;
   logic                            instr_valid;
   logic                            instr_ready;
   logic [EW-1:0]                   instr_out;
   logic [SRC_W-1:0]                instr_src;
   logic                            data_valid;
   logic                            data_ready;
   logic [DATAIN_WIDTH-1:0]         data_out;
   logic                            data_last;
   logic                            busy;

   modport master (
      input  empty_instFIFO, dout_instFIFO, empty_iFIFO, dout_iFIFO, instr_ready, data_ready,
      output pop_n_instFIFO, pop_n_iFIFO, instr_valid, instr_out, instr_src,
             data_valid, data_out, data_last, busy
   );

   modport slave (
      output empty_instFIFO, dout_instFIFO, empty_iFIFO, dout_iFIFO, instr_ready, data_ready,
      input  pop_n_instFIFO, pop_n_iFIFO, instr_valid, instr_out, instr_src,
             data_valid, data_out, data_last, busy
   );
endinterface

// File: rtl/rram_instr_arbiter.sv
// Round-robin merge of NUM_SRC instr/data FIFO pairs; instruction out 1 cycle after pop.
// Grant locks for a data burst; instr_ready/data_ready stall, empty data FIFO stalls the burst.
module rram_instr_arbiter #(
   parameter int NUM_SRC      = 2,
   parameter int INSTR_WIDTH  = 4,
   parameter int OPCODE_WIDTH = 16,
   parameter int DATAIN_WIDTH = 64,
   parameter logic [(1<<INSTR_WIDTH)-1:0] DATA_OPC_MASK = 16'h0010
) (
   input logic                 CLK,
   input logic                 reset,
   rram_instr_arbiter_if.master bus
);
   localparam int EW    = INSTR_WIDTH + OPCODE_WIDTH;
   localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);
   localparam logic [SRC_W:0]   NSRC     = (SRC_W + 1)'(NUM_SRC);

   typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

   state_t           state_q, state_d;
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0] grant_q, grant_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [EW-1:0]    instr_out_q, instr_out_d;

   logic                    found;
   logic [SRC_W-1:0]        pick;
   logic [EW-1:0]           pick_word;
   logic [SRC_W:0]          cand;
   logic                    sel_empty;
   logic [DATAIN_WIDTH-1:0] sel_data;
   logic                    dvld;
   logic [INSTR_WIDTH-1:0]  code;

   assign code = instr_out_q[EW-1 -: INSTR_WIDTH];

   // First non-empty instruction FIFO at or after rr_ptr, wrapping.
   always_comb begin
      found     = 1'b0;
      pick      = '0;
      pick_word = '0;
      cand      = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         cand = {1'b0, rr_ptr_q} + (SRC_W + 1)'(k);
         if (cand >= NSRC) cand = cand - NSRC;
         for (int i = 0; i < NUM_SRC; i++) begin
            if (!found && cand == (SRC_W + 1)'(i) && !bus.empty_instFIFO[i]) begin
               found     = 1'b1;
               pick      = SRC_W'(i);
               pick_word = bus.dout_instFIFO[i*EW +: EW];
            end
         end
      end
   end

   always_comb begin
      sel_empty = 1'b1;
      sel_data  = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (grant_q == SRC_W'(i)) begin
            sel_empty = bus.empty_iFIFO[i];
            sel_data  = bus.dout_iFIFO[i*DATAIN_WIDTH +: DATAIN_WIDTH];
         end
      end
   end

   always_comb begin
      state_d            = state_q;
      rr_ptr_d           = rr_ptr_q;
      grant_d            = grant_q;
      cnt_d              = cnt_q;
      instr_out_d        = instr_out_q;
      bus.pop_n_instFIFO = '1;
      bus.pop_n_iFIFO    = '1;
      bus.data_valid     = 1'b0;
      bus.data_out       = '0;
      bus.data_last      = 1'b0;
      dvld               = 1'b0;
      case (state_q)
         IDLE: begin
            if (found) begin
               bus.pop_n_instFIFO[pick] = 1'b0;
               instr_out_d = pick_word;
               grant_d     = pick;
               rr_ptr_d    = (pick == LAST_SRC) ? '0 : pick + 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.instr_ready) begin
               if (DATA_OPC_MASK[code]) begin
                  cnt_d   = instr_out_q[OPCODE_WIDTH-1 -: 3];
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DATA: begin
            dvld           = ~sel_empty;
            bus.data_valid = dvld;
            bus.data_out   = sel_data;
            bus.data_last  = (cnt_q == 3'd0);
            if (dvld && bus.data_ready) begin
               bus.pop_n_iFIFO[grant_q] = 1'b0;
               if (cnt_q == 3'd0) state_d = IDLE;
               else               cnt_d   = cnt_q - 3'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      // Comb pops would otherwise follow the pre-reset state for one cycle.
      if (reset) begin
         bus.pop_n_instFIFO = '1;
         bus.pop_n_iFIFO    = '1;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         cnt_q       <= '0;
         instr_out_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         cnt_q       <= cnt_d;
         instr_out_q <= instr_out_d;
      end
   end

   assign bus.instr_valid = (state_q == ISSUE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.instr_out   = instr_out_q;
   assign bus.instr_src   = grant_q;
endmodule
